// File: rtl/riskow_uart_pkg.sv
// Shared definitions for the bus-mapped UART transmitter: register offsets,
// STATUS bit layout, transmitter FSM states and a divisor helper.
package riskow_uart_pkg;

    // Word offsets inside the 16-byte register window (address[3:2]).
    localparam logic [1:0] OffData     = 2'd0;
    localparam logic [1:0] OffStatus   = 2'd1;
    localparam logic [1:0] OffDivisor  = 2'd2;
    localparam logic [1:0] OffReserved = 2'd3;

    // STATUS register layout.
    localparam int unsigned StatusFullBit     = 0;
    localparam int unsigned StatusEmptyBit    = 1;
    localparam int unsigned StatusBusyBit     = 2;
    localparam int unsigned StatusOverflowBit = 3;
    localparam int unsigned StatusCountLsb    = 8;
    localparam int unsigned StatusCountWidth  = 4;

    // Transmitter frame states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } txState_e;

    // A programmed divisor of 0 would give a zero-length bit; treat it as 1.
    function automatic logic [15:0] effDivisor(input logic [15:0] divisor);
        return (divisor == 16'd0) ? 16'd1 : divisor;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Single-clock synchronous FIFO holding bytes waiting to be transmitted.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam logic [AW:0] DepthCnt = (AW + 1)'(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wrPtrQ, wrPtrD;
    logic [AW-1:0]    rdPtrQ, rdPtrD;
    logic [AW:0]      countQ, countD;
    logic             doPush, doPop;

    assign full_o  = (countQ == DepthCnt);
    assign empty_o = (countQ == '0);
    assign count_o = countQ;
    assign rdata_o = mem[rdPtrQ];

    // Pop only real entries; push when there is room or a slot frees this cycle.
    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    // Next-state for pointers and occupancy.
    always_comb begin
        wrPtrD = wrPtrQ;
        rdPtrD = rdPtrQ;
        countD = countQ;
        if (doPush) begin
            wrPtrD = wrPtrQ + AW'(1);
        end
        if (doPop) begin
            rdPtrD = rdPtrQ + AW'(1);
        end
        unique case ({doPush, doPop})
            2'b10:   countD = countQ + (AW + 1)'(1);
            2'b01:   countD = countQ - (AW + 1)'(1);
            default: countD = countQ;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else begin
            wrPtrQ <= wrPtrD;
            rdPtrQ <= rdPtrD;
            countQ <= countD;
        end
    end

    // Storage array; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem[wrPtrQ] <= wdata_i;
        end
    end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, a programmable bit
// divisor and a sticky overflow flag. Register reads are combinational and
// return 0 when the window is not addressed, so dataOut can be OR-ed on the bus.
module bus_uart_tx
    import riskow_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hF000_0000,
    parameter logic [15:0] CLKS_PER_BIT = 16'd104,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] dataIn,
    input  logic        busWriteEnable,
    output logic [31:0] dataOut,
    output logic        tx
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    // Bus decode
    logic       selected;
    logic [1:0] offset;
    logic       wrActive;
    logic       wrFire;
    logic       dataWr, statusWr, divisorWr;

    // Write-edge history: a held write only acts in its first cycle.
    logic       prevWrQ;
    logic [1:0] prevOffQ;

    // Registers
    logic [15:0] divisorQ;
    logic        overflowQ, overflowD;

    // FIFO interface
    logic            fifoPop;
    logic            fifoFull, fifoEmpty;
    logic [7:0]      fifoRdata;
    logic [CntW-1:0] fifoCount;

    // Transmitter state
    txState_e    stateQ, stateD;
    logic [15:0] baudCntQ, baudCntD;
    logic [15:0] bitLenQ, bitLenD;
    logic [2:0]  bitCntQ, bitCntD;
    logic [7:0]  shiftQ, shiftD;
    logic        txQ, txD;
    logic        bitEnd;

    logic [31:0] statusWord;
    logic        unusedBits;

    assign unusedBits = ^{dataIn[31:16], address[1:0]};

    assign selected  = (address[31:4] == BASE_ADDR[31:4]);
    assign offset    = address[3:2];
    assign wrActive  = selected && busWriteEnable;
    assign wrFire    = wrActive && !(prevWrQ && (prevOffQ == offset));
    assign dataWr    = wrFire && (offset == OffData);
    assign statusWr  = wrFire && (offset == OffStatus);
    assign divisorWr = wrFire && (offset == OffDivisor);

    uart_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (8)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (dataWr),
        .wdata_i (dataIn[7:0]),
        .pop_i   (fifoPop),
        .rdata_o (fifoRdata),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    // Remember the previous cycle's selected write for edge qualification.
    always_ff @(posedge clk) begin
        if (reset) begin
            prevWrQ  <= 1'b0;
            prevOffQ <= 2'd0;
        end else begin
            prevWrQ  <= wrActive;
            prevOffQ <= offset;
        end
    end

    // Divisor register; only the low half-word is stored.
    always_ff @(posedge clk) begin
        if (reset) begin
            divisorQ <= CLKS_PER_BIT;
        end else if (divisorWr) begin
            divisorQ <= dataIn[15:0];
        end
    end

    // Sticky overflow: set on a dropped byte, cleared by writing 1 to its bit.
    always_comb begin
        overflowD = overflowQ;
        if (statusWr && dataIn[StatusOverflowBit]) begin
            overflowD = 1'b0;
        end else if (dataWr && fifoFull && !fifoPop) begin
            overflowD = 1'b1;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflowQ <= 1'b0;
        end else begin
            overflowQ <= overflowD;
        end
    end

    assign bitEnd = (baudCntQ == (bitLenQ - 16'd1));

    // Frame sequencing: next state, counters, FIFO pop and next line level.
    // The line level is registered, so tx trails the state by one cycle.
    always_comb begin
        stateD   = stateQ;
        baudCntD = baudCntQ;
        bitLenD  = bitLenQ;
        bitCntD  = bitCntQ;
        shiftD   = shiftQ;
        fifoPop  = 1'b0;
        txD      = 1'b1;
        unique case (stateQ)
            StIdle: begin
                if (!fifoEmpty) begin
                    fifoPop  = 1'b1;
                    shiftD   = fifoRdata;
                    bitLenD  = effDivisor(divisorQ);
                    baudCntD = 16'd0;
                    bitCntD  = 3'd0;
                    stateD   = StStart;
                end
            end
            StStart: begin
                txD = 1'b0;
                if (bitEnd) begin
                    baudCntD = 16'd0;
                    bitCntD  = 3'd0;
                    stateD   = StData;
                end else begin
                    baudCntD = baudCntQ + 16'd1;
                end
            end
            StData: begin
                txD = shiftQ[0];
                if (bitEnd) begin
                    baudCntD = 16'd0;
                    shiftD   = {1'b0, shiftQ[7:1]};
                    if (bitCntQ == 3'd7) begin
                        bitCntD = 3'd0;
                        stateD  = StStop;
                    end else begin
                        bitCntD = bitCntQ + 3'd1;
                    end
                end else begin
                    baudCntD = baudCntQ + 16'd1;
                end
            end
            StStop: begin
                txD = 1'b1;
                if (bitEnd) begin
                    baudCntD = 16'd0;
                    if (!fifoEmpty) begin
                        // Chain straight into the next frame without an idle bit.
                        fifoPop = 1'b1;
                        shiftD  = fifoRdata;
                        bitLenD = effDivisor(divisorQ);
                        stateD  = StStart;
                    end else begin
                        stateD = StIdle;
                    end
                end else begin
                    baudCntD = baudCntQ + 16'd1;
                end
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    // Transmitter state registers and glitch-free line driver.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ   <= StIdle;
            baudCntQ <= 16'd0;
            bitLenQ  <= effDivisor(CLKS_PER_BIT);
            bitCntQ  <= 3'd0;
            shiftQ   <= 8'd0;
            txQ      <= 1'b1;
        end else begin
            stateQ   <= stateD;
            baudCntQ <= baudCntD;
            bitLenQ  <= bitLenD;
            bitCntQ  <= bitCntD;
            shiftQ   <= shiftD;
            txQ      <= txD;
        end
    end

    assign tx = txQ;

    // Assemble STATUS from live state.
    always_comb begin
        statusWord                    = 32'd0;
        statusWord[StatusFullBit]     = fifoFull;
        statusWord[StatusEmptyBit]    = fifoEmpty;
        statusWord[StatusBusyBit]     = (stateQ != StIdle);
        statusWord[StatusOverflowBit] = overflowQ;
        statusWord[StatusCountLsb +: StatusCountWidth] = StatusCountWidth'(fifoCount);
    end

    // Zero-latency read mux; idle bus contributes 0.
    always_comb begin
        dataOut = 32'd0;
        if (selected) begin
            unique case (offset)
                OffData:     dataOut = 32'd0;
                OffStatus:   dataOut = statusWord;
                OffDivisor:  dataOut = {16'd0, divisorQ};
                OffReserved: dataOut = 32'd0;
                default:     dataOut = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx: register table, directed frame
// sequences and randomized frames compared with an ideal 8N1 line model.
module tb_bus_uart_tx;

    localparam logic [31:0] Base     = 32'hF000_0000;
    localparam logic [31:0] AData    = Base + 32'h0;
    localparam logic [31:0] AStatus  = Base + 32'h4;
    localparam logic [31:0] ADivisor = Base + 32'h8;
    localparam logic [31:0] AResv    = Base + 32'hC;
    localparam int LogSize = 32768;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] dataIn;
    logic        busWriteEnable;
    logic [31:0] dataOut;
    logic        tx;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc = 0;

    logic       txLog   [LogSize];
    logic       busyLog [LogSize];
    logic [7:0] expBytes [16];

    always #5 clk = ~clk;

    bus_uart_tx #(
        .BASE_ADDR    (Base),
        .CLKS_PER_BIT (16'd104),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .address        (address),
        .dataIn         (dataIn),
        .busWriteEnable (busWriteEnable),
        .dataOut        (dataOut),
        .tx             (tx)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Index k holds the value seen between rising edges k and k+1.
    always @(negedge clk) begin
        if (cyc < LogSize) begin
            txLog[cyc]   <= tx;
            busyLog[cyc] <= dataOut[2];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idleBus();
        address        = AStatus;
        dataIn         = 32'd0;
        busWriteEnable = 1'b0;
    endtask

    // Drive a write for 'hold' cycles; edgeN is the edge that samples it first.
    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data,
                            input int hold, output int unsigned edgeN);
        @(posedge clk);
        #1;
        address        = addr;
        dataIn         = data;
        busWriteEnable = 1'b1;
        edgeN          = cyc + 1;
        repeat (hold) @(posedge clk);
        #1;
        idleBus();
    endtask

    task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
        @(posedge clk);
        #1;
        address        = addr;
        busWriteEnable = 1'b0;
        @(negedge clk);
        data = dataOut;
    endtask

    // Ideal line level i cycles after the edge that sampled the first DATA write.
    function automatic logic expTx(input int i, input int d, input int n);
        int j, f, b;
        if (i < 2) return 1'b1;
        j = i - 2;
        f = j / (10 * d);
        b = (j % (10 * d)) / d;
        if (f >= n) return 1'b1;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return expBytes[f][b - 1];
    endfunction

    task automatic checkFrames(input string name, input int unsigned n0, input int d, input int n);
        int len, mism, first;
        logic expv;
        len   = 2 + 10 * d * n + 6;
        mism  = 0;
        first = -1;
        while (cyc <= n0 + len) @(posedge clk);
        for (int i = 0; i < len; i++) begin
            expv = expTx(i, d, n);
            if (txLog[n0 + i] !== expv) begin
                mism++;
                if (first < 0) first = i;
            end
        end
        tests++;
        if (mism != 0) begin
            fails++;
            $display("FAIL %s: %0d line cycles differ, first at +%0d got %b expected %b",
                     name, mism, first, txLog[n0 + first], expTx(first, d, n));
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t        vt [15];
    logic [31:0] rd;
    int unsigned n0, e;
    int          cnt, d, dEff, busyCnt, busyFirst, lows;

    initial begin
        reset = 1'b1;
        idleBus();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);

        vt[0]  = '{1'b0, AStatus,            32'd0,         1'b1, 32'h0000_0002};
        vt[1]  = '{1'b0, AData,              32'd0,         1'b1, 32'h0000_0000};
        vt[2]  = '{1'b0, ADivisor,           32'd0,         1'b1, 32'h0000_0068};
        vt[3]  = '{1'b0, AResv,              32'd0,         1'b1, 32'h0000_0000};
        vt[4]  = '{1'b0, Base + 32'h10,      32'd0,         1'b1, 32'h0000_0000};
        vt[5]  = '{1'b0, 32'h0000_0004,      32'd0,         1'b1, 32'h0000_0000};
        vt[6]  = '{1'b1, ADivisor,           32'h0001_0010, 1'b0, 32'h0000_0000};
        vt[7]  = '{1'b0, ADivisor,           32'd0,         1'b1, 32'h0000_0010};
        vt[8]  = '{1'b1, Base + 32'h18,      32'h0000_0033, 1'b1, 32'h0000_0000};
        vt[9]  = '{1'b0, Base + 32'h9,       32'd0,         1'b1, 32'h0000_0010};
        vt[10] = '{1'b1, Base + 32'h10,      32'h0000_00AB, 1'b1, 32'h0000_0000};
        vt[11] = '{1'b0, AStatus,            32'd0,         1'b1, 32'h0000_0002};
        vt[12] = '{1'b1, AResv,              32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
        vt[13] = '{1'b0, AResv + 32'h3,      32'd0,         1'b1, 32'h0000_0000};
        vt[14] = '{1'b0, ADivisor + 32'h2,   32'd0,         1'b1, 32'h0000_0010};

        foreach (vt[i]) begin
            @(posedge clk);
            #1;
            address        = vt[i].addr;
            dataIn         = vt[i].data;
            busWriteEnable = vt[i].we;
            @(negedge clk);
            if (vt[i].chk) check($sformatf("vec%0d", i), dataOut, vt[i].exp);
            @(posedge clk);
            #1;
            idleBus();
        end

        // 0x55 at divisor 4: exact waveform and 40 busy cycles.
        busWrite(ADivisor, 32'd4, 1, e);
        expBytes[0] = 8'h55;
        busWrite(AData, 32'h55, 1, n0);
        checkFrames("frame_55", n0, 4, 1);
        repeat (20) @(posedge clk);
        busyCnt   = 0;
        busyFirst = -1;
        for (int i = 0; i <= 60; i++) begin
            if (busyLog[n0 + i] === 1'b1) begin
                busyCnt++;
                if (busyFirst < 0) busyFirst = i;
            end
        end
        check("busy_cycles", busyCnt, 40);
        check("busy_first", busyFirst, 1);

        // Fill the FIFO, overflow it, then clear the sticky flag.
        busWrite(ADivisor, 32'd16, 1, e);
        for (int k = 1; k <= 9; k++) begin
            expBytes[k - 1] = 8'(k);
            busWrite(AData, 32'(k), 1, e);
            if (k == 1) n0 = e;
        end
        busRead(AStatus, rd);
        check("fifo_full", rd, 32'h0000_0805);
        busWrite(AData, 32'h0A, 1, e);
        busRead(AStatus, rd);
        check("overflow_set", rd, 32'h0000_080D);
        busWrite(AStatus, 32'h8, 1, e);
        busRead(AStatus, rd);
        check("overflow_clr", rd, 32'h0000_0805);
        checkFrames("frames_1to9", n0, 16, 9);
        busRead(AStatus, rd);
        check("drained", rd, 32'h0000_0002);

        // A write held three cycles must queue exactly one byte.
        busWrite(ADivisor, 32'd3, 1, e);
        expBytes[0] = 8'hA5;
        busWrite(AData, 32'hA5, 3, n0);
        busRead(AStatus, rd);
        check("held_write_status", rd, 32'h0000_0006);
        checkFrames("held_write_frame", n0, 3, 1);

        // Divisor 0 behaves as one cycle per bit.
        busWrite(ADivisor, 32'd0, 1, e);
        busRead(ADivisor, rd);
        check("div_zero_read", rd, 32'h0000_0000);
        expBytes[0] = 8'h3C;
        busWrite(AData, 32'h3C, 1, n0);
        checkFrames("div_zero_frame", n0, 1, 1);

        // Reset in the middle of data bit 3 with two bytes queued.
        busWrite(ADivisor, 32'd4, 1, e);
        busWrite(AData, 32'hFF, 1, n0);
        busWrite(AData, 32'h11, 1, e);
        busWrite(AData, 32'h22, 1, e);
        while (cyc < n0 + 18) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("busy_before_reset", {31'd0, busyLog[n0 + 18]}, 32'd1);
        check("reset_tx_high", {31'd0, tx}, 32'd1);
        busRead(AStatus, rd);
        check("reset_status", rd, 32'h0000_0002);
        busRead(ADivisor, rd);
        check("reset_divisor", rd, 32'h0000_0068);
        n0 = cyc;
        repeat (150) @(posedge clk);
        lows = 0;
        for (int i = 0; i < 140; i++) if (txLog[n0 + i] !== 1'b1) lows++;
        check("no_frames_after_reset", lows, 0);

        // Randomized bursts checked against the ideal line model.
        for (int t = 0; t < 8; t++) begin
            d    = $urandom_range(0, 5);
            dEff = (d == 0) ? 1 : d;
            cnt  = $urandom_range(1, 4);
            busWrite(ADivisor, 32'(d), 1, e);
            for (int k = 0; k < cnt; k++) begin
                expBytes[k] = 8'($urandom_range(0, 255));
                busWrite(AData, {24'd0, expBytes[k]}, 1, e);
                if (k == 0) n0 = e;
            end
            checkFrames($sformatf("rand%0d_d%0d_n%0d", t, d, cnt), n0, dEff, cnt);
            busRead(AStatus, rd);
            check($sformatf("rand%0d_status", t), rd, 32'h0000_0002);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
